comma_aligner_10b: RTL and testbench

Receive-side symbol aligner that sits directly upstream of the 1-byte 8B/10B decoder. It takes unaligned 10-bit words from the deserializer and hunts for the K28.5 comma. Once it has verified an alignment it holds it, and presents aligned 10-bit symbols, in the decoder's bit order, to the decoder's `i_data10`. The decoder's code-error flags are fed back combinationally, so the aligner drops lock and re-hunts when the link degrades.

---
 rtl/comma_aligner_10b.sv | 190 +++++++++++++++++++
 tb/tb_comma_aligner_10b.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/comma_aligner_10b.sv
// K28.5 comma aligner: hunts for the comma across all ten bit offsets, verifies it,
// then holds the alignment until the decoder reports too many code errors.
module comma_aligner_10b #(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 4,
    parameter int GOOD_RUN   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [9:0] i_data10,
    input  logic       i_code_err,
    output logic       o_valid,
    output logic [9:0] o_data10,
    output logic       o_comma,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [9:0]  r_prev;
    logic        r_valid;
    logic [9:0]  r_data;
    logic        r_comma;
    logic [3:0]  r_offset;
    logic [3:0]  r_lockCnt;
    logic [3:0]  r_errCnt;
    logic [7:0]  r_goodCnt;

    logic [3:0]  w_offsetNext;
    logic [3:0]  w_lockCntNext;
    logic [3:0]  w_errCntNext;
    logic [7:0]  w_goodCntNext;
    logic        w_adopt;

    logic [19:0] w_win;
    logic [9:0]  w_cand [10];
    logic [9:0]  w_commaVec;
    logic        w_hit;
    logic [3:0]  w_hitK;
    logic [3:0]  w_effOff;
    logic [9:0]  w_effData;
    logic        w_effComma;
    logic        w_qualErr;
    logic        w_goodSym;

    assign w_win = {i_data10, r_prev};

    always_comb begin
        for (int k = 0; k < 10; k++) begin
            w_cand[k]     = w_win[k +: 10];
            w_commaVec[k] = (w_win[k +: 7] == 7'b1111100) || (w_win[k +: 7] == 7'b0000011);
        end
    end

    // Scanning downward lets the lowest matching offset overwrite any higher one.
    always_comb begin
        w_hit  = 1'b0;
        w_hitK = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (w_commaVec[k]) begin
                w_hit  = 1'b1;
                w_hitK = 4'(k);
            end
        end
    end

    assign w_qualErr = r_valid & i_code_err;
    assign w_goodSym = r_valid & ~i_code_err & i_valid;

    always_comb begin
        w_stateNext   = r_state;
        w_offsetNext  = r_offset;
        w_lockCntNext = r_lockCnt;
        w_errCntNext  = r_errCnt;
        w_goodCntNext = r_goodCnt;
        w_adopt       = 1'b0;
        case (r_state)
            HUNT: begin
                if (i_valid && w_hit) begin
                    w_adopt       = 1'b1;
                    w_offsetNext  = w_hitK;
                    w_lockCntNext = 4'd1;
                    w_stateNext   = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                // A decoder error outranks a comma arriving in the same cycle.
                if (w_qualErr) begin
                    w_stateNext   = HUNT;
                    w_lockCntNext = 4'd0;
                end else if (i_valid && w_hit) begin
                    if (w_hitK == r_offset) begin
                        if (r_lockCnt != 4'hF) begin
                            w_lockCntNext = r_lockCnt + 4'd1;
                        end
                        if (int'(r_lockCnt) + 1 >= LOCK_COUNT) begin
                            w_stateNext = LOCKED;
                        end
                    end else begin
                        w_adopt       = 1'b1;
                        w_offsetNext  = w_hitK;
                        w_lockCntNext = 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (w_qualErr) begin
                    w_goodCntNext = 8'd0;
                    if (r_errCnt != 4'hF) begin
                        w_errCntNext = r_errCnt + 4'd1;
                    end
                    if (int'(r_errCnt) + 1 >= ERR_LIMIT) begin
                        w_stateNext   = HUNT;
                        w_lockCntNext = 4'd0;
                        w_errCntNext  = 4'd0;
                    end
                end else if (w_goodSym) begin
                    if (int'(r_goodCnt) + 1 >= GOOD_RUN) begin
                        w_goodCntNext = 8'd0;
                        if (r_errCnt != 4'd0) begin
                            w_errCntNext = r_errCnt - 4'd1;
                        end
                    end else begin
                        w_goodCntNext = r_goodCnt + 8'd1;
                    end
                end
            end
            default: begin
                w_stateNext = HUNT;
            end
        endcase
    end

    // The comma that triggers realignment is itself emitted at its own offset.
    assign w_effOff = w_adopt ? w_hitK : r_offset;

    always_comb begin
        w_effData  = w_cand[0];
        w_effComma = w_commaVec[0];
        for (int k = 1; k < 10; k++) begin
            if (w_effOff == 4'(k)) begin
                w_effData  = w_cand[k];
                w_effComma = w_commaVec[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= HUNT;
            r_prev    <= 10'd0;
            r_valid   <= 1'b0;
            r_data    <= 10'd0;
            r_comma   <= 1'b0;
            r_offset  <= 4'd0;
            r_lockCnt <= 4'd0;
            r_errCnt  <= 4'd0;
            r_goodCnt <= 8'd0;
        end else begin
            r_state   <= w_stateNext;
            r_offset  <= w_offsetNext;
            r_lockCnt <= w_lockCntNext;
            r_errCnt  <= w_errCntNext;
            r_goodCnt <= w_goodCntNext;
            r_valid   <= i_valid;
            if (i_valid) begin
                r_data  <= w_effData;
                r_comma <= w_effComma;
                r_prev  <= i_data10;
            end else begin
                r_comma <= 1'b0;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_data10 = r_data;
    assign o_comma  = r_comma;
    assign o_locked = (r_state == LOCKED);
    assign o_offset = r_offset;

endmodule

// File: tb/tb_comma_aligner_10b.sv
// Scoreboard bench for comma_aligner_10b: words are sliced from a hand-built serial
// bit stream and each expected aligned symbol is a slice of that same stream.
module tb_comma_aligner_10b;

    localparam logic [9:0] SYM_A = 10'h17C;
    localparam logic [9:0] SYM_B = 10'h283;
    localparam logic [9:0] SYM_D = 10'h3C0;

    typedef struct packed {
        logic [9:0] data;
        logic       comma;
        logic       locked;
        logic [3:0] offset;
    } exp_t;

    logic       clock;
    logic       rstN;
    logic       i_valid;
    logic [9:0] i_data10;
    logic       i_code_err;
    logic       o_valid;
    logic [9:0] o_data10;
    logic       o_comma;
    logic       o_locked;
    logic [3:0] o_offset;

    logic [255:0] sbits;
    exp_t         expQ[$];
    int           checks = 0;
    int           passes = 0;
    int           symNum = 0;

    comma_aligner_10b #(
        .LOCK_COUNT(3),
        .ERR_LIMIT (4),
        .GOOD_RUN  (4)
    ) dut (
        .i_clk     (clock),
        .i_rst_n   (rstN),
        .i_valid   (i_valid),
        .i_data10  (i_data10),
        .i_code_err(i_code_err),
        .o_valid   (o_valid),
        .o_data10  (o_data10),
        .o_comma   (o_comma),
        .o_locked  (o_locked),
        .o_offset  (o_offset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [16:0] actual, input logic [16:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Word m of the stream is sbits[10m+10 +: 10]; sbits[9:0] stands in for the reset-cleared prev word.
    task automatic applyStimulus(input int m, input logic v, input logic err,
                                 input logic expComma, input logic expLocked, input logic [3:0] expOff);
        exp_t e;
        @(posedge clock);
        #1;
        i_valid    = v;
        i_code_err = err;
        if (v) begin
            i_data10 = sbits[10*m + 10 +: 10];
            e.data   = sbits[10*m + int'(expOff) +: 10];
            e.comma  = expComma;
            e.locked = expLocked;
            e.offset = expOff;
            expQ.push_back(e);
        end else begin
            i_data10 = 10'h2AA;
        end
    endtask

    task automatic putStream(input int start, input int count);
        for (int j = 0; j < count; j++) begin
            sbits[start + 10*j +: 10] = (j % 2 == 0) ? SYM_A : SYM_B;
        end
    endtask

    task automatic doReset();
        @(posedge clock);
        #1;
        rstN       = 1'b0;
        i_valid    = 1'b0;
        i_code_err = 1'b0;
        @(posedge clock);
        #1;
        rstN = 1'b1;
        checkOutput("reset state", {o_valid, o_comma, o_locked, o_data10, o_offset}, 17'd0);
        checkOutput("queue empty at reset", 17'(expQ.size()), 17'd0);
    endtask

    task automatic endTest(input string name);
        @(posedge clock);
        #1;
        i_valid    = 1'b0;
        i_code_err = 1'b0;
        @(negedge clock);
        #1;
        checkOutput({name, " drained"}, 17'(expQ.size()), 17'd0);
    endtask

    // Monitor: every presented symbol must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (o_valid === 1'b1) begin
            symNum++;
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected symbol #%0d: got data %h, expected no output", symNum, o_data10);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("symbol #%0d {data,comma,locked,offset}", symNum),
                            {1'b0, o_data10, o_comma, o_locked, o_offset}, {1'b0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstN       = 1'b0;
        i_valid    = 1'b0;
        i_code_err = 1'b0;
        i_data10   = 10'd0;
        repeat (2) @(posedge clock);
        #1;
        rstN = 1'b1;
        checkOutput("initial reset state", {o_valid, o_comma, o_locked, o_data10, o_offset}, 17'd0);

        $display("[TB] lock at offset 3, then error accounting");
        sbits = '0;
        putStream(13, 20);
        applyStimulus(0, 1, 0, 0, 0, 4'd0);
        applyStimulus(1, 1, 0, 1, 0, 4'd3);
        applyStimulus(2, 1, 0, 1, 0, 4'd3);
        applyStimulus(3, 1, 0, 1, 1, 4'd3);
        for (int m = 4; m <= 6; m++) applyStimulus(m, 1, 1, 1, 1, 4'd3);
        for (int m = 7; m <= 10; m++) applyStimulus(m, 1, 0, 1, 1, 4'd3);
        applyStimulus(11, 1, 1, 1, 1, 4'd3);
        applyStimulus(12, 1, 1, 1, 0, 4'd3);
        applyStimulus(13, 1, 0, 1, 0, 4'd3);
        applyStimulus(14, 1, 0, 1, 0, 4'd3);
        applyStimulus(15, 1, 0, 1, 1, 4'd3);
        endTest("lock/errors");

        $display("[TB] realign in VERIFY after a 1-bit slip");
        doReset();
        sbits = '0;
        putStream(13, 2);
        putStream(34, 6);
        applyStimulus(0, 1, 0, 0, 0, 4'd0);
        applyStimulus(1, 1, 0, 1, 0, 4'd3);
        applyStimulus(2, 1, 0, 1, 0, 4'd3);
        applyStimulus(3, 1, 0, 1, 0, 4'd4);
        applyStimulus(4, 1, 0, 1, 0, 4'd4);
        applyStimulus(5, 1, 0, 1, 1, 4'd4);
        applyStimulus(6, 1, 0, 1, 1, 4'd4);
        endTest("realign");

        $display("[TB] sparse valid");
        doReset();
        sbits = '0;
        putStream(13, 10);
        applyStimulus(0, 1, 0, 0, 0, 4'd0);
        applyStimulus(0, 0, 0, 0, 0, 4'd0);
        applyStimulus(1, 1, 0, 1, 0, 4'd3);
        applyStimulus(0, 0, 0, 0, 0, 4'd0);
        applyStimulus(2, 1, 0, 1, 0, 4'd3);
        applyStimulus(0, 0, 0, 0, 0, 4'd0);
        applyStimulus(3, 1, 0, 1, 1, 4'd3);
        applyStimulus(0, 0, 0, 0, 0, 4'd0);
        applyStimulus(4, 1, 0, 1, 1, 4'd3);

        $display("[TB] reset mid-lock, relock at offset 0");
        doReset();
        sbits = '0;
        putStream(10, 10);
        applyStimulus(0, 1, 0, 0, 0, 4'd0);
        applyStimulus(1, 1, 0, 1, 0, 4'd0);
        applyStimulus(2, 1, 0, 1, 0, 4'd0);
        applyStimulus(3, 1, 0, 1, 1, 4'd0);
        applyStimulus(4, 1, 0, 1, 1, 4'd0);
        endTest("relock");

        $display("[TB] foreign comma at offset 7 while locked at 3");
        doReset();
        sbits = '0;
        putStream(13, 10);
        sbits[53 +: 10] = SYM_D;
        applyStimulus(0, 1, 0, 0, 0, 4'd0);
        applyStimulus(1, 1, 0, 1, 0, 4'd3);
        applyStimulus(2, 1, 0, 1, 0, 4'd3);
        applyStimulus(3, 1, 0, 1, 1, 4'd3);
        applyStimulus(4, 1, 0, 1, 1, 4'd3);
        applyStimulus(5, 1, 0, 0, 1, 4'd3);
        applyStimulus(6, 1, 0, 1, 1, 4'd3);
        applyStimulus(7, 1, 0, 1, 1, 4'd3);
        endTest("foreign comma");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
